// File: rtl/mcpu5_pkg.sv
// mcpu5_pkg: opcodes, sequencer state and halt-cause encodings shared by the MCPU5 sequencer.
package mcpu5_pkg;
   localparam logic [5:0] OP_HALT = 6'b111111;
   localparam logic [5:0] OP_OUT  = 6'b111011;
   localparam logic [5:0] OP_NOP  = OP_HALT;
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALTED} state_e;
   typedef enum logic [2:0] {
      HC_NONE   = 3'd0,
      HC_CMD    = 3'd1,
      HC_OPHALT = 3'd2,
      HC_BP     = 3'd3,
      HC_LIMIT  = 3'd4,
      HC_FAULT  = 3'd5
   } cause_e;
endpackage

// File: rtl/mcpu5_prog_mem.sv
// mcpu5_prog_mem: 2**ADDR_W x 6 program store, single write port, registered read.
module mcpu5_prog_mem
   import mcpu5_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [5:0]        wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [5:0]        rdata
);
   logic [5:0] mem [2**ADDR_W];
   logic [5:0] rd_q;
   always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_q <= OP_HALT;
      else if (re) rd_q <= mem[raddr];
   assign rdata = rd_q;
endmodule

// File: rtl/mcpu5_prog_sequencer.sv
// mcpu5_prog_sequencer: feeds the MCPU5 core one stored instruction per two clocks,
// owns core reset and stops on command, HALT opcode, breakpoint, step budget or PC fault.
module mcpu5_prog_sequencer
   import mcpu5_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_reset,
   input  logic              cmd_halt,
   input  logic              cmd_run,
   input  logic              cmd_step,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [5:0]        prog_data,
   input  logic              bp_en,
   input  logic [7:0]        bp_addr,
   input  logic [CNT_W-1:0]  step_limit,
   input  logic [7:0]        cpu_pc,
   input  logic [7:0]        cpu_accu,
   output logic [5:0]        cpu_inst,
   output logic              cpu_step,
   output logic              cpu_rst,
   output logic [7:0]        out_data,
   output logic              out_valid,
   output logic              busy,
   output logic [2:0]        halt_cause
);
   state_e             state_q, state_d;
   logic               mode_step_q, mode_step_d;
   logic               first_q, first_d;
   logic               halt_req_q, halt_req_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   cause_e             cause_q, cause_d;
   logic [7:0]         out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic [5:0]         inst;
   logic [CNT_W-1:0]   cnt_inc;
   logic               fault, bp_hit, go_run, go_step, idle_or_halted;

   mcpu5_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (prog_we && idle_or_halted),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (state_q == ST_FETCH),
      .raddr (cpu_pc[ADDR_W-1:0]),
      .rdata (inst)
   );

   assign idle_or_halted = (state_q == ST_IDLE) || (state_q == ST_HALTED);
   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
   assign fault   = (cpu_pc >> ADDR_W) != 8'd0;
   assign bp_hit  = bp_en && (cpu_pc == bp_addr) && !first_q;
   // cmd_halt outranks run/step even where it has no effect of its own
   assign go_run  = cmd_run && !cmd_halt;
   assign go_step = cmd_step && !cmd_halt && !cmd_run;

   always_comb begin
      state_d     = state_q;
      mode_step_d = mode_step_q;
      first_d     = first_q;
      halt_req_d  = halt_req_q;
      cnt_d       = cnt_q;
      cause_d     = cause_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      if (cmd_reset) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         cause_d    = HC_NONE;
         halt_req_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HALTED: if (go_run || go_step) begin
               state_d     = ST_FETCH;
               mode_step_d = go_step;
               first_d     = 1'b1;
               halt_req_d  = 1'b0;
               cause_d     = HC_NONE;
               cnt_d       = go_run ? '0 : cnt_q;
            end
            ST_FETCH: begin
               first_d    = 1'b0;
               halt_req_d = halt_req_q || cmd_halt;
               state_d    = (fault || bp_hit) ? ST_HALTED : ST_EXEC;
               cause_d    = fault ? HC_FAULT : bp_hit ? HC_BP : cause_q;
            end
            default: if (inst == OP_HALT) begin
               state_d = ST_HALTED;
               cause_d = HC_OPHALT;
            end else begin
               cnt_d       = cnt_inc;
               out_valid_d = inst == OP_OUT;
               out_data_d  = inst == OP_OUT ? cpu_accu : out_data_q;
               halt_req_d  = 1'b0;
               state_d     = ST_HALTED;
               if (mode_step_q) cause_d = HC_NONE;
               else if (step_limit != '0 && cnt_inc == step_limit) cause_d = HC_LIMIT;
               else if (halt_req_q || cmd_halt) cause_d = HC_CMD;
               else state_d = ST_FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_step_q <= 1'b0;
         first_q     <= 1'b0;
         halt_req_q  <= 1'b0;
         cnt_q       <= '0;
         cause_q     <= HC_NONE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_step_q <= mode_step_d;
         first_q     <= first_d;
         halt_req_q  <= halt_req_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end

   assign cpu_inst   = (state_q == ST_EXEC) ? inst : OP_NOP;
   assign cpu_step   = (state_q == ST_EXEC) && (inst != OP_HALT);
   assign cpu_rst    = state_q == ST_IDLE;
   assign busy       = (state_q == ST_FETCH) || (state_q == ST_EXEC);
   assign halt_cause = cause_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
endmodule

// File: tb/tb_mcpu5_prog_sequencer.sv
// tb_mcpu5_prog_sequencer: directed bench with a tiny core model driving cpu_pc/cpu_accu.
module tb_mcpu5_prog_sequencer;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_reset = 1'b0, cmd_halt = 1'b0, cmd_run = 1'b0, cmd_step = 1'b0;
   logic        prog_we = 1'b0;
   logic [4:0]  prog_addr = '0;
   logic [5:0]  prog_data = '0;
   logic        bp_en = 1'b0;
   logic [7:0]  bp_addr = '0;
   logic [11:0] step_limit = '0;
   logic [7:0]  pc = '0, accu = '0, poke_val = '0;
   logic        poke = 1'b0;
   logic [5:0]  cpu_inst;
   logic        cpu_step, cpu_rst, out_valid, busy;
   logic [7:0]  out_data;
   logic [2:0]  halt_cause;
   int          step_cnt = 0, out_cnt = 0, s0, o0, errors = 0, checks = 0;

   mcpu5_prog_sequencer dut (
      .clk(clk), .rst(rst), .cmd_reset(cmd_reset), .cmd_halt(cmd_halt), .cmd_run(cmd_run),
      .cmd_step(cmd_step), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .bp_en(bp_en), .bp_addr(bp_addr), .step_limit(step_limit), .cpu_pc(pc), .cpu_accu(accu),
      .cpu_inst(cpu_inst), .cpu_step(cpu_step), .cpu_rst(cpu_rst), .out_data(out_data),
      .out_valid(out_valid), .busy(busy), .halt_cause(halt_cause)
   );

   always #5 clk = ~clk;

   // minimal core: LDI 010iii loads imm, 100000 jumps to accu, everything else advances pc
   always @(posedge clk) begin
      if (cpu_step) step_cnt <= step_cnt + 1;
      if (out_valid) out_cnt <= out_cnt + 1;
      if (cpu_rst) begin
         pc   <= '0;
         accu <= '0;
      end else if (poke) accu <= poke_val;
      else if (cpu_step) begin
         if (cpu_inst[5:3] == 3'b010) accu <= {5'b0, cpu_inst[2:0]};
         pc <= (cpu_inst == 6'b100000) ? accu : pc + 8'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cmd(input logic [3:0] c);
      {cmd_reset, cmd_halt, cmd_run, cmd_step} = c;
      @(negedge clk);
      {cmd_reset, cmd_halt, cmd_run, cmd_step} = 4'b0;
   endtask

   task automatic load(input logic [4:0] a, input logic [5:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_inst", cpu_inst, 6'h3f);
      chk("rst_step", cpu_step, 0);
      chk("rst_out", {out_valid, out_data}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cause", halt_cause, 0);

      load(0, 6'b010011); load(1, 6'b111011); load(2, 6'b111111);
      s0 = step_cnt; o0 = out_cnt;
      cmd(4'b0010);
      chk("run_busy", busy, 1);
      chk("run_cpu_rst", cpu_rst, 0);
      wait_done("p1_done");
      chk("p1_cause", halt_cause, 2);
      chk("p1_steps", step_cnt - s0, 2);
      chk("p1_outs", out_cnt - o0, 1);
      chk("p1_out_data", out_data, 8'h03);
      chk("p1_halted_rst", cpu_rst, 0);

      cmd(4'b1000);
      for (int i = 0; i < 8; i++) load(5'(i), 6'b000001);
      step_limit = 12'd5;
      s0 = step_cnt;
      cmd(4'b0010);
      wait_done("lim_done");
      chk("lim_cause", halt_cause, 4);
      chk("lim_steps", step_cnt - s0, 5);
      chk("lim_pc", pc, 5);

      cmd(4'b1000);
      bp_en = 1'b1; bp_addr = 8'h02;
      s0 = step_cnt;
      cmd(4'b0010);
      wait_done("bp_done");
      chk("bp_cause", halt_cause, 3);
      chk("bp_pc", pc, 2);
      chk("bp_steps", step_cnt - s0, 2);
      step_limit = 12'd3;
      cmd(4'b0010);
      wait_done("bp_resume_done");
      chk("bp_resume_cause", halt_cause, 4);
      chk("bp_resume_pc", pc, 5);
      bp_en = 1'b0;

      cmd(4'b1000);
      step_limit = '0;
      cmd(4'b0010);
      @(negedge clk);
      cmd(4'b0100);
      wait_done("halt_done");
      chk("halt_cause", halt_cause, 1);
      chk("halt_pc", pc, 1);

      cmd(4'b1000);
      for (int i = 1; i <= 3; i++) begin
         s0 = step_cnt;
         cmd(4'b0001);
         wait_done("step_done");
         chk("step_cause", halt_cause, 0);
         chk("step_one", step_cnt - s0, 1);
         chk("step_pc", pc, i);
         @(negedge clk);
         chk("step_busy_low", busy, 0);
         chk("step_not_idle", cpu_rst, 0);
      end

      load(3, 6'b100000);
      poke_val = 8'h40; poke = 1'b1;
      @(negedge clk);
      poke = 1'b0;
      cmd(4'b0001);
      wait_done("jmpa_done");
      chk("jmpa_pc", pc, 8'h40);
      s0 = step_cnt;
      cmd(4'b0001);
      wait_done("fault_done");
      chk("fault_cause", halt_cause, 5);
      chk("fault_steps", step_cnt - s0, 0);

      cmd(4'b1000);
      load(0, 6'b111011);
      step_limit = 12'd2;
      s0 = step_cnt; o0 = out_cnt;
      cmd(4'b0010);
      prog_we = 1'b1; prog_addr = 5'd1; prog_data = 6'h3f;
      @(negedge clk);
      prog_we = 1'b0;
      chk("abort_exec_step", cpu_step, 1);
      chk("abort_exec_inst", cpu_inst, 6'b111011);
      cmd(4'b1000);
      chk("abort_cpu_rst", cpu_rst, 1);
      chk("abort_busy", busy, 0);
      chk("abort_steps", step_cnt - s0, 1);
      @(negedge clk);
      chk("abort_no_out", out_cnt - o0, 0);
      chk("abort_cause", halt_cause, 0);
      o0 = out_cnt;
      cmd(4'b0010);
      wait_done("rerun_done");
      chk("store_unchanged", halt_cause, 4);
      chk("rerun_outs", out_cnt - o0, 1);
      chk("rerun_out_data", out_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
